// File: rtl/spi_i2s_rxfifo_ctrl_if.sv
// Bus bundle for the SPI_I2S RX FIFO read controller: FIFO read port, DMA burst port and CPU pop port.
// The master modport is the controller side; slave is the FIFO/DMA/CPU environment.
interface spi_i2s_rxfifo_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int FILL_W = 4
);
  logic [FILL_W-1:0] fifo_fill;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_read;

  logic              dma_req;
  logic              dma_gnt;
  logic              dma_valid;
  logic [DATA_W-1:0] dma_data;
  logic              dma_last;
  logic              dma_ready;

  logic              cpu_rd_req;
  logic              cpu_rd_valid;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              cpu_rd_err;

  modport master (
    input  fifo_fill, fifo_data, dma_gnt, dma_ready, cpu_rd_req,
    output fifo_read, dma_req, dma_valid, dma_data, dma_last,
           cpu_rd_valid, cpu_rd_data, cpu_rd_err
  );

  modport slave (
    output fifo_fill, fifo_data, dma_gnt, dma_ready, cpu_rd_req,
    input  fifo_read, dma_req, dma_valid, dma_data, dma_last,
           cpu_rd_valid, cpu_rd_data, cpu_rd_err
  );
endinterface

// File: rtl/spi_i2s_rxfifo_ctrl.sv
// SPI_I2S RX FIFO read-side controller: CPU single pops (priority) and watermark DMA bursts.
// Optional idle-partial timeout with flush burst is built when SPI_I2S_RXCTRL_TIMEOUT_EN is defined.
module spi_i2s_rxfifo_ctrl #(
  parameter int DATA_W = 32,
  parameter int FILL_W = 4,
  parameter int TO_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              dma_en_i,
  input  logic [FILL_W-1:0] watermark_i,
  input  logic [TO_W-1:0]   timeout_cycles_i,
  input  logic              irq_clr_i,
  output logic              irq_wm_o,
  output logic              irq_timeout_o,
  spi_i2s_rxfifo_ctrl_if.master rx_bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_RD  = 3'd1,
    CPU_CAP = 3'd2,
    DMA_REQ = 3'd3,
    DMA_RD  = 3'd4,
    DMA_CAP = 3'd5,
    DMA_OUT = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;
  logic [FILL_W-1:0] burst_q, burst_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic [FILL_W-1:0] wm_eff_s;
  logic              cpu_want_s;
  logic              to_fire_s;

  // Clamp the programmed watermark into the legal 1..8 range.
  always_comb begin
    if (watermark_i == '0) begin
      wm_eff_s = FILL_W'(1);
    end else if (watermark_i > FILL_W'(8)) begin
      wm_eff_s = FILL_W'(8);
    end else begin
      wm_eff_s = watermark_i;
    end
  end

  assign cpu_want_s = pend_q | rx_bus.cpu_rd_req;
  assign irq_wm_o   = (rx_bus.fifo_fill >= wm_eff_s);

`ifdef SPI_I2S_RXCTRL_TIMEOUT_EN
  logic [TO_W-1:0]   to_q, to_d;
  logic [FILL_W-1:0] fill_q;
  logic              irq_q, irq_d;
  logic              to_arm_s;

  // Count idle cycles with a stable partial fill; a set in the same cycle as irq_clr wins.
  always_comb begin
    to_arm_s  = enable_i && (state_q == IDLE) && (rx_bus.fifo_fill != '0) &&
                (rx_bus.fifo_fill < wm_eff_s) && !cpu_want_s && (rx_bus.fifo_fill == fill_q);
    to_fire_s = 1'b0;
    to_d      = '0;
    if (to_arm_s) begin
      if ((timeout_cycles_i != '0) && ((to_q + TO_W'(1)) == timeout_cycles_i)) begin
        to_fire_s = 1'b1;
        to_d      = '0;
      end else begin
        to_fire_s = 1'b0;
        to_d      = to_q + TO_W'(1);
      end
    end else begin
      to_d = '0;
    end
    irq_d = to_fire_s | (irq_q & ~irq_clr_i);
  end

  // Timeout counter, fill history and sticky flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_q   <= '0;
      fill_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      to_q   <= to_d;
      fill_q <= rx_bus.fifo_fill;
      irq_q  <= irq_d;
    end
  end

  assign irq_timeout_o = irq_q;
`else
  logic unused_to_s;
  assign unused_to_s   = ^{timeout_cycles_i, irq_clr_i};
  assign to_fire_s     = 1'b0;
  assign irq_timeout_o = 1'b0;
`endif

  // Next-state and datapath updates; disabling the block discards any in-flight word.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | rx_bus.cpu_rd_req;
    err_d   = 1'b0;
    burst_d = burst_q;
    hold_d  = hold_q;
    rdat_d  = rdat_q;
    case (state_q)
      IDLE: begin
        if (cpu_want_s) begin
          if (rx_bus.fifo_fill != '0) begin
            state_d = CPU_RD;
          end else begin
            err_d  = 1'b1;
            rdat_d = '0;
            pend_d = 1'b0;
          end
        end else if (dma_en_i && (rx_bus.fifo_fill >= wm_eff_s)) begin
          state_d = DMA_REQ;
          burst_d = wm_eff_s;
        end else if (to_fire_s && dma_en_i) begin
          state_d = DMA_REQ;
          burst_d = rx_bus.fifo_fill;
        end else begin
          state_d = IDLE;
        end
      end
      CPU_RD:  state_d = CPU_CAP;
      CPU_CAP: begin
        rdat_d  = rx_bus.fifo_data;
        pend_d  = rx_bus.cpu_rd_req;
        state_d = IDLE;
      end
      DMA_REQ: begin
        if (rx_bus.dma_gnt) begin
          state_d = DMA_RD;
        end else begin
          state_d = DMA_REQ;
        end
      end
      DMA_RD:  state_d = DMA_CAP;
      DMA_CAP: begin
        hold_d  = rx_bus.fifo_data;
        state_d = DMA_OUT;
      end
      DMA_OUT: begin
        if (rx_bus.dma_ready) begin
          burst_d = burst_q - FILL_W'(1);
          if (burst_q == FILL_W'(1)) begin
            state_d = IDLE;
          end else begin
            state_d = DMA_RD;
          end
        end else begin
          state_d = DMA_OUT;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable_i) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      err_d   = 1'b0;
      burst_d = '0;
      hold_d  = '0;
      rdat_d  = '0;
    end else begin
      state_d = state_d;
    end
  end

  // Control and data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      burst_q <= '0;
      hold_q  <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      burst_q <= burst_d;
      hold_q  <= hold_d;
      rdat_q  <= rdat_d;
    end
  end

  // The FIFO word is only present during CPU_CAP, so the response passes it straight through then.
  assign rx_bus.fifo_read    = (state_q == CPU_RD) || (state_q == DMA_RD);
  assign rx_bus.dma_req      = (state_q == DMA_REQ);
  assign rx_bus.dma_valid    = (state_q == DMA_OUT);
  assign rx_bus.dma_data     = hold_q;
  assign rx_bus.dma_last     = (state_q == DMA_OUT) && (burst_q == FILL_W'(1));
  assign rx_bus.cpu_rd_valid = (state_q == CPU_CAP) || err_q;
  assign rx_bus.cpu_rd_err   = err_q;
  assign rx_bus.cpu_rd_data  = (state_q == CPU_CAP) ? rx_bus.fifo_data : rdat_q;

endmodule

// File: tb/tb_spi_i2s_rxfifo_ctrl.sv
// Self-checking bench for spi_i2s_rxfifo_ctrl: directed CPU/DMA/abort/timeout scenarios
// against a FIFO emulation, word-order scoreboard and rule checks evaluated every cycle.
module tb_spi_i2s_rxfifo_ctrl;
  localparam int DW = 32;
  localparam int FW = 4;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          dma_en = 1'b0;
  logic          irq_clr = 1'b0;
  logic [FW-1:0] watermark = 4'd4;
  logic [TW-1:0] timeout_cycles = 16'd0;
  logic          irq_wm, irq_timeout;

  spi_i2s_rxfifo_ctrl_if #(.DATA_W(DW), .FILL_W(FW)) bus ();

  spi_i2s_rxfifo_ctrl #(.DATA_W(DW), .FILL_W(FW), .TO_W(TW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable_i         (enable),
    .dma_en_i         (dma_en),
    .watermark_i      (watermark),
    .timeout_cycles_i (timeout_cycles),
    .irq_clr_i        (irq_clr),
    .irq_wm_o         (irq_wm),
    .irq_timeout_o    (irq_timeout),
    .rx_bus           (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // FIFO emulation: registered output, valid only the cycle after a pop
  logic [31:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_fill = FW'(wr_ptr - rd_ptr);
  always @(posedge clk) begin
    if (bus.fifo_read) begin
      bus.fifo_data <= mem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end else begin
      bus.fifo_data <= 32'h0;
    end
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // Grant and ready responders
  bit auto_gnt = 1'b1;
  int rdy_mode = 1;  // 0 low, 1 high, 2 random
  initial begin
    bus.dma_gnt = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.dma_gnt = auto_gnt && bus.dma_req;
    end
  end
  initial begin
    bus.dma_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 2) bus.dma_ready = 1'($urandom_range(0, 1));
      else               bus.dma_ready = (rdy_mode == 1);
    end
  end

  function automatic logic wm_rule(input logic [FW-1:0] f, input logic [FW-1:0] w);
    int e;
    e = (w == 0) ? 1 : ((w > 8) ? 8 : int'(w));
    return int'(f) >= e;
  endfunction

  // Scoreboard and per-cycle rules
  logic [31:0] dma_exp[$];
  int          burst_len = 0;
  int          beat_n = 0;
  int          bursts_done = 0;
  logic        prev_rd = 1'b0, prev_v = 1'b0, prev_r = 1'b0, prev_last = 1'b0, prev_en = 1'b0;
  logic [31:0] prev_d = 32'h0;
  logic [31:0] exp_w;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("irq_wm", irq_wm, wm_rule(bus.fifo_fill, watermark));
      if (bus.fifo_read) begin
        chk("rd_nonempty", bus.fifo_fill != 4'd0, 1'b1);
        chk("rd_consec", prev_rd, 1'b0);
      end
      if (prev_v && !prev_r && prev_en && enable) begin
        chk("hold_valid", bus.dma_valid, 1'b1);
        chk("hold_data", bus.dma_data, prev_d);
        chk("hold_last", bus.dma_last, prev_last);
      end
      if (enable && bus.dma_valid && bus.dma_ready) begin
        beat_n++;
        if (dma_exp.size() > 0) exp_w = dma_exp.pop_front();
        else                    exp_w = 32'hDEAD_BEEF;
        chk("dma_data", bus.dma_data, exp_w);
        chk("dma_last", bus.dma_last, beat_n == burst_len);
        if (bus.dma_last || beat_n >= burst_len) begin
          beat_n = 0;
          bursts_done++;
        end
      end
      if (!enable) begin
        beat_n = 0;
        dma_exp.delete();
      end
    end
    prev_rd   = bus.fifo_read;
    prev_v    = bus.dma_valid;
    prev_r    = bus.dma_ready;
    prev_d    = bus.dma_data;
    prev_last = bus.dma_last;
    prev_en   = enable;
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic nsample();
    @(negedge clk); #1;
  endtask

  // One CPU pop with hand-computed timing: read at +1, response at +2
  task automatic cpu_pop(input string nm, input logic [31:0] w);
    step(); bus.cpu_rd_req = 1'b1;
    nsample(); chk({nm, "_rd0"}, bus.fifo_read, 1'b0);
    step(); bus.cpu_rd_req = 1'b0;
    nsample(); chk({nm, "_rd1"}, bus.fifo_read, 1'b1);
    chk({nm, "_v1"}, bus.cpu_rd_valid, 1'b0);
    nsample(); chk({nm, "_valid"}, bus.cpu_rd_valid, 1'b1);
    chk({nm, "_data"}, bus.cpu_rd_data, w);
    chk({nm, "_err"}, bus.cpu_rd_err, 1'b0);
    nsample(); chk({nm, "_vdrop"}, bus.cpu_rd_valid, 1'b0);
  endtask

  task automatic wait_bursts(input int n);
    int t = 0;
    while (bursts_done < n && t < 400) begin nsample(); t++; end
    chk("bursts_done", bursts_done, n);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rd"},   bus.fifo_read, 1'b0);
    chk({nm, "_req"},  bus.dma_req, 1'b0);
    chk({nm, "_dv"},   bus.dma_valid, 1'b0);
    chk({nm, "_dd"},   bus.dma_data, 32'h0);
    chk({nm, "_dl"},   bus.dma_last, 1'b0);
    chk({nm, "_cv"},   bus.cpu_rd_valid, 1'b0);
    chk({nm, "_ce"},   bus.cpu_rd_err, 1'b0);
    chk({nm, "_cd"},   bus.cpu_rd_data, 32'h0);
  endtask

  initial begin
    int n;
    int seen;
    bus.cpu_rd_req = 1'b0;
    repeat (3) @(posedge clk);
    nsample();
    chk_all_zero("reset");
    chk("reset_irqto", irq_timeout, 1'b0);
    step(); rst_n = 1'b1; enable = 1'b1;

    // Empty pop: error strobe one cycle after the request, no FIFO read
    step(); bus.cpu_rd_req = 1'b1;
    nsample(); chk("ep_rd0", bus.fifo_read, 1'b0);
    step(); bus.cpu_rd_req = 1'b0;
    nsample(); chk("ep_valid", bus.cpu_rd_valid, 1'b1);
    chk("ep_err", bus.cpu_rd_err, 1'b1);
    chk("ep_data", bus.cpu_rd_data, 32'h0);
    chk("ep_rd1", bus.fifo_read, 1'b0);
    nsample(); chk("ep_vdrop", bus.cpu_rd_valid, 1'b0);
    chk("ep_edrop", bus.cpu_rd_err, 1'b0);

    // CPU pops in FIFO order
    step(); push(32'hA5A5_0001); push(32'hA5A5_0002); push(32'hA5A5_0003);
    cpu_pop("pop1", 32'hA5A5_0001);
    cpu_pop("pop2", 32'hA5A5_0002);
    cpu_pop("pop3", 32'hA5A5_0003);

    // Burst of 4 with random backpressure
    step(); watermark = 4'd4; dma_en = 1'b1; rdy_mode = 2; burst_len = 4;
    for (int i = 0; i < 4; i++) dma_exp.push_back(32'hB000_0000 + i);
    for (int i = 0; i < 4; i++) begin step(); push(32'hB000_0000 + i); end
    nsample(); chk("req_early", bus.dma_req, 1'b0);
    nsample(); chk("req_on", bus.dma_req, 1'b1);
    nsample(); chk("req_drop", bus.dma_req, 1'b0);
    nsample(); chk("cap_nov", bus.dma_valid, 1'b0);
    nsample(); chk("first_valid", bus.dma_valid, 1'b1);
    chk("first_data", bus.dma_data, 32'hB000_0000);
    wait_bursts(1);
    nsample(); chk("b1_fill", bus.fifo_fill, 4'd0);
    chk("b1_idle_req", bus.dma_req, 1'b0);

    // CPU wins over a simultaneous watermark hit; mid-burst request served after the last beat
    step(); dma_en = 1'b0; rdy_mode = 1;
    for (int i = 0; i < 5; i++) push(32'hD000_0000 + i);
    for (int i = 1; i < 5; i++) dma_exp.push_back(32'hD000_0000 + i);
    step(); dma_en = 1'b1; bus.cpu_rd_req = 1'b1;
    step(); bus.cpu_rd_req = 1'b0;
    nsample(); chk("prio_rd", bus.fifo_read, 1'b1);
    chk("prio_noreq", bus.dma_req, 1'b0);
    nsample(); chk("prio_valid", bus.cpu_rd_valid, 1'b1);
    chk("prio_data", bus.cpu_rd_data, 32'hD000_0000);
    n = 0;
    while (beat_n < 1 && n < 100) begin nsample(); n++; end
    step(); push(32'hD000_0005); bus.cpu_rd_req = 1'b1;
    step(); bus.cpu_rd_req = 1'b0;
    wait_bursts(2);
    n = 0;
    do begin nsample(); n++; end while (!bus.cpu_rd_valid && n < 20);
    chk("mid_lat", n, 3);
    chk("mid_data", bus.cpu_rd_data, 32'hD000_0005);

    // Abort during beat 2 of 4, then re-enable
    step(); rdy_mode = 1; burst_len = 4;
    for (int i = 0; i < 4; i++) dma_exp.push_back(32'hE000_0000 + i);
    for (int i = 0; i < 4; i++) push(32'hE000_0000 + i);
    n = 0;
    while (beat_n < 1 && n < 100) begin nsample(); n++; end
    rdy_mode = 0;
    n = 0;
    do begin nsample(); n++; end while (!bus.dma_valid && n < 20);
    chk("ab_beat2", bus.dma_data, 32'hE000_0001);
    enable = 1'b0;
    nsample(); chk_all_zero("abort");
    step(); enable = 1'b1; rdy_mode = 1; burst_len = 4;
    for (int i = 2; i < 6; i++) dma_exp.push_back(32'hE000_0000 + i);
    push(32'hE000_0004); push(32'hE000_0005);
    n = 0;
    do begin nsample(); n++; end while (!bus.dma_req && n < 20);
    chk("reen_req", bus.dma_req, 1'b1);
    wait_bursts(3);

    // Idle partial fill below watermark
    step(); watermark = 4'd8; timeout_cycles = 16'd100; burst_len = 2;
`ifdef SPI_I2S_RXCTRL_TIMEOUT_EN
    dma_exp.push_back(32'hF000_0000); dma_exp.push_back(32'hF000_0001);
    push(32'hF000_0000); push(32'hF000_0001);
    n = 0;
    while (!irq_timeout && n < 200) begin nsample(); n++; end
    chk("to_irq", irq_timeout, 1'b1);
    chk("to_window", (n >= 98) && (n <= 104), 1'b1);
    wait_bursts(4);
    step(); irq_clr = 1'b1;
    step(); irq_clr = 1'b0;
    nsample(); chk("to_clr", irq_timeout, 1'b0);
`else
    push(32'hF000_0000); push(32'hF000_0001);
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      nsample();
      seen = seen | int'(bus.dma_req) | int'(irq_timeout);
    end
    chk("noto_seen", seen, 0);
    chk("noto_fill", bus.fifo_fill, 4'd2);
    step(); irq_clr = 1'b1;
    step(); irq_clr = 1'b0;
    nsample(); chk("noto_irq", irq_timeout, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
